// File: rtl/ln_range_reduce.sv
// ----------------------------------------------------------------------------
// ln_range_reduce
//   Range-reduction front end for the hyperbolic-CORDIC ln path. Normalises an
//   unsigned Q2.14 operand x to m in [1.0, 2.0) and a signed exponent k with
//   x = m * 2^k. The block does one shift per clock and uses valid/ready
//   handshakes on both sides.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   in_valid/x     operand handshake (x is unsigned Q2.14)
//   in_ready       high only in IDLE
//   out_valid      high only in DONE; m/k/zero_err stay stable while it is high
//   out_ready      consumer accepts the result
//   m              normalised mantissa, Q2.14
//   k              signed exponent, range -14..+1
//   zero_err       operand was zero; m and k are 0
//   ln2_term       k*ln2 in signed Q16.16 (only when LN2_TERM_EN is defined)
//
// Configuration macro: LN2_TERM_EN adds the ln2_term output.
// ----------------------------------------------------------------------------
module ln_range_reduce (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] m,
   output logic [4:0]  k,
`ifdef LN2_TERM_EN
   output logic        zero_err,
   output logic [31:0] ln2_term
`else
   output logic        zero_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t      r_state;
   logic        r_in_ready;
   logic        r_out_valid;
   logic [15:0] r_work;
   logic [4:0]  r_k;
   logic        r_zero;

`ifdef LN2_TERM_EN
   logic [31:0] r_ln2;
   logic [31:0] w_ln2;
   // Signed k times ln2 (Q16.16). The product is taken modulo 2^32, so a
   // sign-extended k gives the correct two's-complement result.
   assign w_ln2    = {{27{r_k[4]}}, r_k} * 32'd45426;
   assign ln2_term = r_ln2;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign m         = r_work;
   assign k         = r_k;
   assign zero_err  = r_zero;

   // DONE spends its first cycle raising out_valid. The result is already
   // final at that point, so this only sets the latency: the handshake flags
   // are pure registered decodes of the state.
   // A nonzero operand always has a set bit, so SHIFT reaches bit 14 after
   // at most one right shift or at most 14 left shifts. The loop is bounded
   // without needing a counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_work      <= 16'h0000;
         r_k         <= 5'd0;
         r_zero      <= 1'b0;
`ifdef LN2_TERM_EN
         r_ln2       <= 32'h0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_k        <= 5'd0;
                  r_work     <= x;
                  if (x == 16'h0000) begin
                     r_zero  <= 1'b1;
`ifdef LN2_TERM_EN
                     r_ln2   <= 32'h0;
`endif
                     r_state <= S_DONE;
                  end else begin
                     r_zero  <= 1'b0;
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               if (r_work[15]) begin
                  // Only possible on the first pass (x >= 2.0). LSB is dropped.
                  r_work <= {1'b0, r_work[15:1]};
                  r_k    <= r_k + 5'd1;
               end else if (r_work[14]) begin
`ifdef LN2_TERM_EN
                  r_ln2   <= w_ln2;
`endif
                  r_state <= S_DONE;
               end else begin
                  r_work <= {r_work[14:0], 1'b0};
                  r_k    <= r_k - 5'd1;
               end
            end
            S_DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ln_range_reduce.sv
module tb_ln_range_reduce;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] m;
   logic [4:0]  k;
   logic        zero_err;
`ifdef LN2_TERM_EN
   logic [31:0] ln2_term;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   typedef struct {
      logic [15:0] m;
      logic [4:0]  k;
      logic        z;
      logic [31:0] ln2;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   ln_range_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .m         (m),
      .k         (k),
`ifdef LN2_TERM_EN
      .zero_err  (zero_err),
      .ln2_term  (ln2_term)
`else
      .zero_err  (zero_err)
`endif
   );

   // Reference: locate the leading one, then derive k and m from its position.
   function automatic exp_t model(input logic [15:0] xv);
      exp_t e;
      int   p;
      int   kk;
      logic [31:0] kk32;
      p = -1;
      for (int i = 0; i < 16; i++) if (xv[i]) p = i;
      if (p < 0) begin
         e.m = 16'h0; e.k = 5'd0; e.z = 1'b1; e.ln2 = 32'h0; e.lat = 1;
      end else begin
         kk   = p - 14;
         kk32 = kk;
         e.m  = (p >= 14) ? (xv >> (p - 14)) : (xv << (14 - p));
         e.k  = kk32[4:0];
         e.z  = 1'b0;
         e.ln2 = kk32 * 32'd45426;
         e.lat = 2 + ((kk < 0) ? -kk : kk);
      end
      return e;
   endfunction

   // Waits for in_ready, then presents xv for one accepting edge and queues
   // the expected result. It returns just after the accepting edge.
   task automatic issue(input logic [15:0] xv);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      x = xv; in_valid = 1'b1;
      sb.push_back(model(xv));
      @(posedge clk); #1;
      in_valid = 1'b0; x = 16'hDEAD;
   endtask

   // Counts edges after the accepting edge until out_valid is seen; -1 on timeout.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; x = 16'h0; out_ready = 1'b0;
      #12;
      n_checks++;
      if ({in_ready, out_valid, m, k, zero_err} !== {1'b1, 1'b0, 16'h0, 5'd0, 1'b0}) begin
         n_errs++;
         $display("FAIL reset: got rdy=%b vld=%b m=%h k=%h z=%b", in_ready, out_valid, m, k, zero_err);
      end
`ifdef LN2_TERM_EN
      n_checks++;
      if (ln2_term !== 32'h0) begin n_errs++; $display("FAIL reset_ln2: got %h exp 0", ln2_term); end
`endif
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_vectors;
      logic [15:0] tbl[$];
      exp_t e;
      int   lat;
      tbl = '{16'h4000, 16'h0100, 16'hC001, 16'h0001, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h2000};
      for (int i = 0; i < 12; i++) tbl.push_back(16'($urandom));
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         issue(tbl[i]);
         wait_valid(lat);
         e = sb.pop_front();
         n_checks++;
         if (lat !== e.lat) begin
            n_errs++; $display("FAIL latency x=%h: got %0d exp %0d", tbl[i], lat, e.lat);
         end
         n_checks++;
         if ({m, k, zero_err} !== {e.m, e.k, e.z}) begin
            n_errs++;
            $display("FAIL result x=%h: got m=%h k=%h z=%b exp m=%h k=%h z=%b",
                     tbl[i], m, k, zero_err, e.m, e.k, e.z);
         end
`ifdef LN2_TERM_EN
         n_checks++;
         if (ln2_term !== e.ln2) begin
            n_errs++; $display("FAIL ln2 x=%h: got %h exp %h", tbl[i], ln2_term, e.ln2);
         end
`endif
         @(posedge clk); #1;
         n_checks++;
         if ({in_ready, out_valid} !== 2'b10) begin
            n_errs++; $display("FAIL release x=%h: got rdy=%b vld=%b exp rdy=1 vld=0", tbl[i], in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      int   lat;
      out_ready = 1'b0;
      issue(16'h3000);
      wait_valid(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 3) begin n_errs++; $display("FAIL bp_latency: got %0d exp 3", lat); end
      for (int c = 0; c < 5; c++) begin
         x = 16'h0001; in_valid = c[0];
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, in_ready, m, k, zero_err} !== {1'b1, 1'b0, e.m, e.k, 1'b0}) begin
            n_errs++;
            $display("FAIL bp_hold cyc=%0d: got vld=%b rdy=%b m=%h k=%h exp m=6000 k=1f",
                     c, out_valid, in_ready, m, k);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_errs++; $display("FAIL bp_release: got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int   lat;
      out_ready = 1'b1;
      issue(16'h0010);
      @(posedge clk); #1;
      @(posedge clk); #1;        // third SHIFT cycle is now in progress
      rst = 1'b1;
      #1;
      void'(sb.pop_front());
      n_checks++;
      if ({in_ready, out_valid, m, k} !== {1'b1, 1'b0, 16'h0, 5'd0}) begin
         n_errs++;
         $display("FAIL reset_mid: got rdy=%b vld=%b m=%h k=%h exp rdy=1 vld=0 m=0 k=0",
                  in_ready, out_valid, m, k);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      issue(16'h8000);
      wait_valid(lat);
      e = sb.pop_front();
      n_checks++;
      if ({m, k, zero_err} !== {16'h4000, 5'd1, 1'b0} || lat !== e.lat) begin
         n_errs++;
         $display("FAIL after_reset: got m=%h k=%h z=%b lat=%0d exp m=4000 k=01 z=0 lat=%0d",
                  m, k, zero_err, lat, e.lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   lat;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(16'h0040 << i);
         wait_valid(lat);
         e = sb.pop_front();
         n_checks++;
         if ({m, k, lat} !== {e.m, e.k, e.lat}) begin
            n_errs++;
            $display("FAIL b2b i=%0d: got m=%h k=%h lat=%0d exp m=%h k=%h lat=%0d",
                     i, m, k, lat, e.m, e.k, e.lat);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
